// File: rtl/riscy_pkg.sv
// riscy_pkg: shared ALU-instruction encodings and the legality rule for the decode stage.
// Contents: XLEN, opcode constants, funct3 enum, funct7 constants, alu_legal() helper.
package riscy_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    // F7_ALT selects SUB (with ADD) or SRA (with SR) on OP; on OP-IMM only the
    // right shift may carry it, and SLLI must have an all-zero upper field.
    function automatic logic alu_legal(input logic [31:0] instr);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = instr[31:25];
        f3 = instr[14:12];
        if (instr[6:0] == OPC_OP)
            return f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        if (instr[6:0] == OPC_OP_IMM)
            return f3 == F3_SLL ? f7 == F7_BASE :
                   f3 == F3_SR  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32 x XLEN register file, two combinational read ports, one write port.
// Ports: clk, rst (sync, active-high, clears all entries); we/waddr/wdata write port;
//        raddr1/rdata1 and raddr2/rdata2 read ports. x0 always reads 0 and ignores writes.
module regfile
    import riscy_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = raddr1 == 5'd0 ? '0 : mem[raddr1];
    assign rdata2 = raddr2 == 5'd0 ? '0 : mem[raddr2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I OP/OP-IMM decode and issue with RAW scoreboard, feeding the ALU.
// Ports: clk, rst (sync, active-high); fetch side if_valid/if_ready/if_instr;
//        write-back wb_en/wb_addr/wb_data; flush; ALU side ex_ready/ex_valid,
//        funct3, funct7, rs1, rs2, rd_addr; illegal (one-cycle pulse).
// Option: DECODE_BYPASS_EN lets a source read wb_data in the write-back cycle
//         instead of waiting a cycle for the pending bit to clear.
module decode_stage
    import riscy_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [4:0]      rd_addr,
    output logic            illegal
);

    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic [2:0]      f3;
    logic            is_op;
    logic            is_imm;
    logic            is_shift;
    logic            legal;
    logic            f7_bit;
    logic            byp1;
    logic            byp2;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] rf1;
    logic [XLEN-1:0] rf2;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] op_b;
    logic [31:0]     pending;
    logic [31:0]     pending_nx;

    assign rs1_idx  = if_instr[19:15];
    assign rs2_idx  = if_instr[24:20];
    assign rd_idx   = if_instr[11:7];
    assign f3       = if_instr[14:12];
    assign is_op    = if_instr[6:0] == OPC_OP;
    assign is_imm   = if_instr[6:0] == OPC_OP_IMM;
    assign is_shift = f3 == F3_SLL || f3 == F3_SR;
    assign legal    = alu_legal(if_instr);
    assign f7_bit   = is_op ? if_instr[30] : (is_imm && f3 == F3_SR) ? if_instr[30] : 1'b0;

    regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_idx),
        .rdata1 (rf1),
        .raddr2 (rs2_idx),
        .rdata2 (rf2)
    );

`ifdef DECODE_BYPASS_EN
    assign byp1 = wb_en && wb_addr == rs1_idx && rs1_idx != 5'd0;
    assign byp2 = wb_en && wb_addr == rs2_idx && rs2_idx != 5'd0;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign src1 = byp1 ? wb_data : rf1;
    assign src2 = byp2 ? wb_data : rf2;
    assign op_b = is_op    ? src2 :
                  is_shift ? {27'b0, rs2_idx} :
                             {{20{if_instr[31]}}, if_instr[31:20]};

    // rs1 is always considered a source; rs2 only when it names a register (OP).
    assign hazard   = (pending[rs1_idx] && !byp1) || (is_op && pending[rs2_idx] && !byp2);
    assign if_ready = !rst && !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // Clears are applied before the set so a same-edge set of the same index wins.
    // A flushed instruction only releases its rd if the ALU did not take it this cycle.
    always_comb begin
        pending_nx = pending;
        if (wb_en && wb_addr != 5'd0) pending_nx[wb_addr] = 1'b0;
        if (flush && ex_valid && !ex_ready) pending_nx[rd_addr] = 1'b0;
        if (accept && legal && rd_idx != 5'd0) pending_nx[rd_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            ex_valid <= 1'b0;
            illegal  <= 1'b0;
            funct3   <= 3'b0;
            funct7   <= 1'b0;
            rs1      <= '0;
            rs2      <= '0;
            rd_addr  <= 5'd0;
        end else begin
            pending <= pending_nx;
            illegal <= accept && !legal;
            if (accept && legal) begin
                ex_valid <= 1'b1;
                funct3   <= f3;
                funct7   <= f7_bit;
                rs1      <= src1;
                rs2      <= op_b;
                rd_addr  <= rd_idx;
            end else if (flush || ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized check of decode_stage against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_addr;
    logic        illegal;

    int total = 0;
    int bad = 0;

`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush),
        .ex_ready (ex_ready),
        .ex_valid (ex_valid),
        .funct3   (funct3),
        .funct7   (funct7),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd_addr  (rd_addr),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Architectural model: register values, busy registers, and the issued instruction.
    bit [31:0] m_regs [32];
    bit        m_busy [32];
    bit        m_ev;
    bit        m_ill;
    bit [2:0]  m_f3;
    bit        m_f7;
    bit [31:0] m_a;
    bit [31:0] m_b;
    bit [4:0]  m_rd;

    typedef struct {
        bit        op;
        bit        imm;
        bit        legal;
        bit [4:0]  rd;
        bit [4:0]  a;
        bit [4:0]  b;
        bit [2:0]  f3;
        bit        f7;
        bit [31:0] immv;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic dec_t decode(input bit [31:0] w);
        dec_t d;
        bit [6:0] top;
        top    = w[31:25];
        d.op   = w[6:0] == 7'h33;
        d.imm  = w[6:0] == 7'h13;
        d.rd   = w[11:7];
        d.a    = w[19:15];
        d.b    = w[24:20];
        d.f3   = w[14:12];
        d.f7   = 1'b0;
        d.immv = {{20{w[31]}}, w[31:20]};
        d.legal = 1'b0;
        if (d.op) begin
            d.f7 = w[30];
            d.legal = top == 0 || (top == 7'h20 && (d.f3 == 0 || d.f3 == 5));
        end else if (d.imm) begin
            if (d.f3 == 1 || d.f3 == 5) d.immv = 32'(d.b);
            if (d.f3 == 5) d.f7 = w[30];
            if (d.f3 == 1) d.legal = top == 0;
            else if (d.f3 == 5) d.legal = top == 0 || top == 7'h20;
            else d.legal = 1'b1;
        end
        return d;
    endfunction

    function automatic bit bypassed(input bit [4:0] i, input bit wbe, input bit [4:0] wba);
        return BYP && wbe && wba == i && i != 0;
    endfunction

    function automatic bit [31:0] read_reg(input bit [4:0] i, input bit wbe, input bit [4:0] wba,
                                           input bit [31:0] wbd);
        if (i == 0) return 0;
        if (bypassed(i, wbe, wba)) return wbd;
        return m_regs[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        m_ev = 0; m_ill = 0; m_f3 = 0; m_f7 = 0; m_a = 0; m_b = 0; m_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1; if_valid = 1; if_instr = 32'h00500093; wb_en = 0; wb_addr = 0;
        wb_data = 0; flush = 0; ex_ready = 1;
        @(negedge clk);
        chk("rst_if_ready", if_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic wbe,
                        input logic [4:0] wba, input logic [31:0] wbd, input logic fl,
                        input logic exr, output logic seen_rdy);
        dec_t d;
        bit   haz;
        bit   e_rdy;
        bit   acc;
        if_valid = iv; if_instr = ins; wb_en = wbe; wb_addr = wba; wb_data = wbd;
        flush = fl; ex_ready = exr;
        @(negedge clk);
        d = decode(ins);
        haz = (m_busy[d.a] && !bypassed(d.a, wbe, wba)) ||
              (d.op && m_busy[d.b] && !bypassed(d.b, wbe, wba));
        e_rdy = !fl && !haz && (!m_ev || exr);
        chk("if_ready", if_ready, e_rdy);
        chk("ex_valid", ex_valid, m_ev);
        chk("illegal", illegal, m_ill);
        chk("funct3", funct3, m_f3);
        chk("funct7", funct7, m_f7);
        chk("rs1", rs1, m_a);
        chk("rs2", rs2, m_b);
        chk("rd_addr", rd_addr, m_rd);
        seen_rdy = if_ready;
        @(posedge clk);
        acc = iv && e_rdy;
        if (wbe && wba != 0) m_busy[wba] = 0;
        if (fl && m_ev && !exr) m_busy[m_rd] = 0;
        if (acc && d.legal && d.rd != 0) m_busy[d.rd] = 1;
        m_ill = acc && !d.legal;
        if (acc && d.legal) begin
            m_ev = 1;
            m_f3 = d.f3;
            m_f7 = d.f7;
            m_a  = read_reg(d.a, wbe, wba, wbd);
            m_b  = d.op ? read_reg(d.b, wbe, wba, wbd) : d.immv;
            m_rd = d.rd;
        end else if (fl || exr) begin
            m_ev = 0;
        end
        if (wbe && wba != 0) m_regs[wba] = wbd;
        #1;
    endtask

    function automatic bit [31:0] rand_instr();
        int k;
        bit [6:0] top;
        bit [4:0] rd, a, b;
        bit [2:0] f3;
        bit [11:0] im;
        k  = $urandom_range(0, 9);
        rd = 5'($urandom_range(0, 7));
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0, 1: top = 7'h00;
            2: top = 7'h20;
            default: top = 7'($urandom);
        endcase
        im = 12'($urandom);
        if (k < 4) return {top, b, a, f3, rd, 7'h33};
        if (k < 8) return (f3 == 1 || f3 == 5) ? {top, b, a, f3, rd, 7'h13} : {im, a, f3, rd, 7'h13};
        return $urandom;
    endfunction

    logic r;

    initial begin
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, r);

        // addi x1,x0,5
        step(1, 32'h00500093, 0, 0, 0, 0, 1, r);
        chk("addi_valid", ex_valid, 1);
        chk("addi_f3", funct3, 0);
        chk("addi_f7", funct7, 0);
        chk("addi_rs1", rs1, 0);
        chk("addi_rs2", rs2, 5);
        chk("addi_rd", rd_addr, 1);

        // x1 = 0xF0 via write-back, then srai x2,x1,3
        step(0, 0, 1, 1, 32'hF0, 0, 1, r);
        step(1, 32'h4030D113, 0, 0, 0, 0, 1, r);
        chk("srai_f3", funct3, 5);
        chk("srai_f7", funct7, 1);
        chk("srai_rs1", rs1, 32'hF0);
        chk("srai_rs2", rs2, 3);

        // RAW: addi x1 then add x3,x1,x1 stalls until write-back
        step(1, 32'h00500093, 0, 0, 0, 0, 1, r);
        step(1, 32'h001081B3, 0, 0, 0, 0, 1, r);
        chk("raw_stall", r, 0);
        step(1, 32'h001081B3, 1, 1, 5, 0, 1, r);
        chk("raw_wb_cycle", r, BYP);
        if (!BYP) begin
            step(1, 32'h001081B3, 0, 0, 0, 0, 1, r);
            chk("raw_after_wb", r, 1);
        end
        chk("raw_rs1", rs1, 5);
        chk("raw_rs2", rs2, 5);
        chk("raw_rd", rd_addr, 3);

        // Back-pressure: addi x4,x0,7 waits while ex_ready is low
        step(1, 32'h00700213, 0, 0, 0, 0, 0, r);
        chk("bp_stall0", r, 0);
        step(1, 32'h00700213, 0, 0, 0, 0, 0, r);
        chk("bp_stall1", r, 0);
        chk("bp_hold_rd", rd_addr, 3);
        step(1, 32'h00700213, 0, 0, 0, 0, 1, r);
        chk("bp_release", r, 1);
        chk("bp_rd", rd_addr, 4);

        // Flush before the ALU takes addi x4; x4 must no longer be pending
        step(0, 0, 0, 0, 0, 1, 0, r);
        chk("flush_valid", ex_valid, 0);
        step(1, 32'h000202B3, 0, 0, 0, 0, 1, r);
        chk("flush_no_stall", r, 1);
        chk("flush_next_rd", rd_addr, 5);

        // Illegal funct7 on OP
        step(1, 32'h02000033, 0, 0, 0, 0, 1, r);
        chk("ill_pulse", illegal, 1);
        chk("ill_valid", ex_valid, 0);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk("ill_one_cycle", illegal, 0);

        // Randomized traffic, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            bit [4:0] wa;
            int busy_q[$];
            if (i == 1500) do_reset();
            busy_q = {};
            for (int j = 1; j < 32; j++) if (m_busy[j]) busy_q.push_back(j);
            wa = (busy_q.size() > 0 && $urandom_range(0, 9) < 7)
                 ? 5'(busy_q[$urandom_range(0, busy_q.size() - 1)])
                 : 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 3, wa, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
